// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock through a single
// WIDTH+1-bit subtract; divide-by-zero short-circuits straight to FIN.
module seq_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dz
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  // Borrow out of the subtract (w_diff MSB) selects restore vs. keep.
  always_comb begin
    w_shift   = {r_rem, r_quo[WIDTH-1]};
    w_diff    = w_shift + ~{1'b0, r_div} + {{WIDTH{1'b0}}, 1'b1};
    w_rem_nxt = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    w_quo_nxt = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy  <= 1'b1;
            r_div <= divisor;
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              dz        <= 1'b1;
              done      <= 1'b1;
              r_state   <= S_FIN;
            end else begin
              r_rem   <= '0;
              r_quo   <= dividend;
              r_cnt   <= CW'(WIDTH);
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - CW'(1);
          // Results are registered on the last step so they appear with done in FIN.
          if (r_cnt == CW'(1)) begin
            quotient  <= w_quo_nxt;
            remainder <= w_rem_nxt;
            dz        <= 1'b0;
            done      <= 1'b1;
            r_state   <= S_FIN;
          end
        end
        S_FIN: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: table vectors plus hand-written sequences at WIDTH=4,
// exhaustive and random sweeps, scoreboard queues popped on done.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start4 = 1'b0, start8 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy4, done4, dz4, busy8, done8, dz8;
  logic [3:0] quo4, rem4;
  logic [7:0] quo8, rem8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_divider #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .dividend(a4), .divisor(b4),
    .busy(busy4), .done(done4), .quotient(quo4), .remainder(rem4), .dz(dz4)
  );

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(a8), .divisor(b8),
    .busy(busy8), .done(done8), .quotient(quo8), .remainder(rem8), .dz(dz8)
  );

  typedef struct {
    logic [7:0] a, b, q, r;
    logic       dz;
    int         acc;
  } exp_t;

  typedef struct {
    logic [3:0] a, b, q, r;
    logic       dz;
  } vec_t;

  exp_t q4[$];
  exp_t q8[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // done is sampled after edge N+W (normal) or edge N (dz), N being the accept edge.
  task automatic check_res(input int w, input exp_t e, input logic [7:0] q,
                           input logic [7:0] r, input logic d);
    chk("quotient", {24'd0, q}, {24'd0, e.q});
    chk("remainder", {24'd0, r}, {24'd0, e.r});
    chk("dz", {31'd0, d}, {31'd0, e.dz});
    chk("latency", cyc - e.acc, e.dz ? 0 : w);
    if (e.b != 0) begin
      chk("invariant_qd_plus_r", int'(q) * int'(e.b) + int'(r), {24'd0, e.a});
      chk("invariant_r_lt_d", {31'd0, r < e.b}, 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) chk("done4_unexpected", 32'd1, 32'd0);
      else check_res(4, q4.pop_front(), {4'd0, quo4}, {4'd0, rem4}, dz4);
    end
    if (done8 === 1'b1) begin
      if (q8.size() == 0) chk("done8_unexpected", 32'd1, 32'd0);
      else check_res(8, q8.pop_front(), quo8, rem8, dz8);
    end
  end

  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.a = a; e.b = b; e.acc = 0;
    if (b == 0) begin
      e.q = (w == 4) ? 8'h0F : 8'hFF; e.r = a; e.dz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic wait_idle(input int w);
    int guard = 0;
    @(negedge clk);
    while (((w == 4) ? busy4 : busy8) !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Drive one operation; push is skipped when the op is going to be aborted.
  task automatic run_op(input int w, input exp_t e, input bit push);
    wait_idle(w);
    if (w == 4) begin start4 = 1'b1; a4 = e.a[3:0]; b4 = e.b[3:0]; end
    else        begin start8 = 1'b1; a8 = e.a;      b8 = e.b;      end
    @(posedge clk); #1;
    e.acc = cyc;
    if (push) begin
      if (w == 4) q4.push_back(e); else q8.push_back(e);
    end
    start4 = 1'b0; start8 = 1'b0;
  endtask

  function automatic exp_t from_vec(input vec_t v);
    exp_t e;
    e.a = {4'd0, v.a}; e.b = {4'd0, v.b}; e.q = {4'd0, v.q}; e.r = {4'd0, v.r};
    e.dz = v.dz; e.acc = 0;
    return e;
  endfunction

  initial begin
    vec_t tv[7];
    exp_t e;
    int   guard;
    tv[0] = '{4'd13, 4'd3, 4'd4,  4'd1, 1'b0};
    tv[1] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0};
    tv[2] = '{4'd0,  4'd7, 4'd0,  4'd0, 1'b0};
    tv[3] = '{4'd3,  4'd5, 4'd0,  4'd3, 1'b0};
    tv[4] = '{4'd9,  4'd0, 4'hF,  4'd9, 1'b1};
    tv[5] = '{4'd14, 4'd4, 4'd3,  4'd2, 1'b0};
    tv[6] = '{4'd11, 4'd2, 4'd5,  4'd1, 1'b0};

    #3;
    chk("reset_busy", {31'd0, busy4}, 32'd0);
    chk("reset_done", {31'd0, done4}, 32'd0);
    chk("reset_quotient", {28'd0, quo4}, 32'd0);
    chk("reset_remainder", {28'd0, rem4}, 32'd0);
    chk("reset_dz", {31'd0, dz4}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_op(4, from_vec(tv[i]), 1'b1);

    // Start held high for 20 edges: accepts at offsets 0,6,12,18; operands
    // are disturbed mid-op and restored before each re-accept.
    wait_idle(4);
    start4 = 1'b1; a4 = tv[5].a; b4 = tv[5].b;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i % 6 == 0) begin
        e = from_vec(tv[5]); e.acc = cyc; q4.push_back(e);
      end
      if (i % 6 == 2) begin a4 = 4'd7; b4 = 4'd1; end
      if (i % 6 == 5) begin a4 = tv[5].a; b4 = tv[5].b; end
      if (i % 6 == 3) chk("busy_in_run", {31'd0, busy4}, 32'd1);
    end
    start4 = 1'b0;

    // Start pulses while busy are ignored.
    run_op(4, from_vec(tv[0]), 1'b1);
    @(negedge clk); start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;

    // Async reset during the second RUN cycle of 11/2 aborts without done.
    run_op(4, from_vec(tv[6]), 1'b0);
    @(posedge clk); @(posedge clk); #2;
    chk("busy_before_abort", {31'd0, busy4}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy4}, 32'd0);
    chk("abort_done", {31'd0, done4}, 32'd0);
    chk("abort_quotient", {28'd0, quo4}, 32'd0);
    chk("abort_remainder", {28'd0, rem4}, 32'd0);
    chk("abort_dz", {31'd0, dz4}, 32'd0);
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    run_op(4, from_vec(tv[6]), 1'b1);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(4, model(4, 8'(a), 8'(b)), 1'b1);

    run_op(8, model(8, 8'd255, 8'd0), 1'b1);
    run_op(8, model(8, 8'd255, 8'd1), 1'b1);
    run_op(8, model(8, 8'd254, 8'd255), 1'b1);
    for (int i = 0; i < 150; i++)
      run_op(8, model(8, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))), 1'b1);

    guard = 0;
    while ((q4.size() != 0 || q8.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("pending_results", q4.size() + q8.size(), 32'd0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
